// File: rtl/soft_reset_sequencer.sv
// soft_reset_sequencer
//   Produces a software-requested reset pulse on the active-low AXI reset net
//   that feeds the per-clock reset distribution. For each request it blocks new
//   AXI traffic, drains outstanding transactions (bounded), holds reset low for
//   a minimum width, then waits for every downstream domain to enter and leave
//   reset (each wait bounded) before reporting completion and status.
//
// Ports
//   CLK_IN            control clock
//   CLK_IN_rst        synchronous reset, active-high
//   SOFT_RST_REQ      request, sampled only while idle
//   TXN_START         AXI transaction accepted (+1 outstanding)
//   TXN_END           AXI transaction completed (-1 outstanding)
//   DOMAIN_RST_N_IN   async per-domain peripheral_aresetn feedback
//   AXI_RESET_N_OUT   drives ext_reset_in; 0 = reset
//   BLOCK_NEW_TXN     master must stop issuing transactions
//   SOFT_RST_BUSY     sequence in progress
//   SOFT_RST_DONE     one-cycle completion pulse
//   SOFT_RST_STATUS   [0] drain timeout, [1] handshake timeout; held until next request
//
// state      | meaning
// -----------+---------------------------------------------------------------
// IDLE       | waiting for SOFT_RST_REQ
// DRAIN      | new traffic blocked, waiting for outstanding count to reach 0
// ASSERT     | reset driven low; waiting for pulse width and all domains in reset
// WAIT_EXIT  | reset released; waiting for all domains to leave reset
// DONE       | single cycle after the completion pulse is registered

module soft_reset_sequencer #(
    parameter int NUM_DOMAINS     = 5,
    parameter int PULSE_CYCLES    = 16,
    parameter int CNT_W           = 8,
    parameter int QUIESCE_TIMEOUT = 1024,
    parameter int HS_TIMEOUT      = 4096,
    parameter int SYNC_STAGES     = 3
) (
    input  logic                   CLK_IN,
    input  logic                   CLK_IN_rst,
    input  logic                   SOFT_RST_REQ,
    input  logic                   TXN_START,
    input  logic                   TXN_END,
    input  logic [NUM_DOMAINS-1:0] DOMAIN_RST_N_IN,
    output logic                   AXI_RESET_N_OUT,
    output logic                   BLOCK_NEW_TXN,
    output logic                   SOFT_RST_BUSY,
    output logic                   SOFT_RST_DONE,
    output logic [1:0]             SOFT_RST_STATUS
);

    localparam int TMR_MAX = (QUIESCE_TIMEOUT > HS_TIMEOUT) ? QUIESCE_TIMEOUT : HS_TIMEOUT;
    localparam int TMR_W   = $clog2(TMR_MAX + 1);
    localparam int PLS_W   = $clog2(PULSE_CYCLES + 1);

    localparam logic [TMR_W-1:0] DRAIN_LAST = TMR_W'(QUIESCE_TIMEOUT - 1);
    localparam logic [TMR_W-1:0] HS_LAST    = TMR_W'(HS_TIMEOUT - 1);
    // Loaded on ASSERT entry; reaching zero marks PULSE_CYCLES edges spent low.
    localparam logic [PLS_W-1:0] PLS_LOAD   = PLS_W'(PULSE_CYCLES - 1);
    localparam logic [CNT_W-1:0] CNT_MAX    = '1;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_DRAIN,
        ST_ASSERT,
        ST_WAIT_EXIT,
        ST_DONE
    } state_t;

    state_t                 state;
    logic [CNT_W-1:0]       txn_cnt;
    logic [CNT_W-1:0]       cnt_step;
    logic [TMR_W-1:0]       timer;
    logic [PLS_W-1:0]       pls_cnt;
    logic [NUM_DOMAINS-1:0] sync_ff [SYNC_STAGES];
    logic [NUM_DOMAINS-1:0] synced;
    logic                   all_in;
    logic                   all_out;

    // Feedback synchronizers reset to 1 so an idle domain reads as "out of reset".
    always_ff @(posedge CLK_IN) begin
        if (CLK_IN_rst) begin
            for (int i = 0; i < SYNC_STAGES; i++) begin
                sync_ff[i] <= '1;
            end
        end else begin
            sync_ff[0] <= DOMAIN_RST_N_IN;
            for (int i = 1; i < SYNC_STAGES; i++) begin
                sync_ff[i] <= sync_ff[i-1];
            end
        end
    end

    assign synced  = sync_ff[SYNC_STAGES-1];
    assign all_in  = ~|synced;
    assign all_out = &synced;

    // Saturating up/down step; simultaneous start and end cancel out.
    always_comb begin
        cnt_step = txn_cnt;
        if (TXN_START && !TXN_END && (txn_cnt != CNT_MAX)) begin
            cnt_step = txn_cnt + CNT_W'(1);
        end else if (TXN_END && !TXN_START && (txn_cnt != '0)) begin
            cnt_step = txn_cnt - CNT_W'(1);
        end
    end

    always_ff @(posedge CLK_IN) begin
        if (CLK_IN_rst) begin
            state           <= ST_IDLE;
            txn_cnt         <= '0;
            timer           <= '0;
            pls_cnt         <= '0;
            AXI_RESET_N_OUT <= 1'b1;
            BLOCK_NEW_TXN   <= 1'b0;
            SOFT_RST_BUSY   <= 1'b0;
            SOFT_RST_DONE   <= 1'b0;
            SOFT_RST_STATUS <= 2'b00;
        end else begin
            txn_cnt       <= cnt_step;
            SOFT_RST_DONE <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (SOFT_RST_REQ) begin
                        state           <= ST_DRAIN;
                        SOFT_RST_BUSY   <= 1'b1;
                        BLOCK_NEW_TXN   <= 1'b1;
                        SOFT_RST_STATUS <= 2'b00;
                        timer           <= '0;
                    end
                end
                ST_DRAIN: begin
                    if ((txn_cnt == '0) || (timer == DRAIN_LAST)) begin
                        // Timeout only counts when transactions are still pending.
                        if (txn_cnt != '0) begin
                            SOFT_RST_STATUS[0] <= 1'b1;
                        end
                        state           <= ST_ASSERT;
                        AXI_RESET_N_OUT <= 1'b0;
                        txn_cnt         <= '0;   // in-flight transactions die with the reset
                        timer           <= '0;
                        pls_cnt         <= PLS_LOAD;
                    end else begin
                        timer <= timer + TMR_W'(1);
                    end
                end
                ST_ASSERT: begin
                    if (pls_cnt != '0) begin
                        pls_cnt <= pls_cnt - PLS_W'(1);
                    end
                    if ((pls_cnt == '0) && (all_in || (timer == HS_LAST))) begin
                        if (!all_in) begin
                            SOFT_RST_STATUS[1] <= 1'b1;
                        end
                        state           <= ST_WAIT_EXIT;
                        AXI_RESET_N_OUT <= 1'b1;
                        timer           <= '0;
                    end else begin
                        timer <= timer + TMR_W'(1);
                    end
                end
                ST_WAIT_EXIT: begin
                    if (all_out || (timer == HS_LAST)) begin
                        if (!all_out) begin
                            SOFT_RST_STATUS[1] <= 1'b1;
                        end
                        state         <= ST_DONE;
                        SOFT_RST_DONE <= 1'b1;
                        SOFT_RST_BUSY <= 1'b0;
                        BLOCK_NEW_TXN <= 1'b0;
                    end else begin
                        timer <= timer + TMR_W'(1);
                    end
                end
                ST_DONE: begin
                    state <= ST_IDLE;
                end
                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_soft_reset_sequencer.sv
// Bench for soft_reset_sequencer. Downstream domains are modelled as a delay
// line on AXI_RESET_N_OUT with optional per-bit tie-offs; each request is
// measured as edge offsets (fall, rise, done) from the request edge, and the
// expected offsets are computed arithmetically from the sequencing rules.

module tb_soft_reset_sequencer;

    localparam int ND      = 5;
    localparam int LAG_MAX = 32;
    localparam int SYNC    = 3;
    localparam int PULSE   = 16;
    localparam int QTO     = 1024;
    localparam int HTO     = 4096;

    logic          clk = 1'b0;
    logic          rst;
    logic          req;
    logic          ts;
    logic          te;
    logic [ND-1:0] dom;
    logic          axi_n;
    logic          block;
    logic          busy;
    logic          done;
    logic [1:0]    status;

    always #5 clk = ~clk;

    soft_reset_sequencer #(
        .NUM_DOMAINS(ND), .PULSE_CYCLES(PULSE), .CNT_W(8),
        .QUIESCE_TIMEOUT(QTO), .HS_TIMEOUT(HTO), .SYNC_STAGES(SYNC)
    ) dut (
        .CLK_IN(clk), .CLK_IN_rst(rst), .SOFT_RST_REQ(req), .TXN_START(ts),
        .TXN_END(te), .DOMAIN_RST_N_IN(dom), .AXI_RESET_N_OUT(axi_n),
        .BLOCK_NEW_TXN(block), .SOFT_RST_BUSY(busy), .SOFT_RST_DONE(done),
        .SOFT_RST_STATUS(status)
    );

    int n_vec = 0;
    int n_err = 0;

    logic          hist [LAG_MAX];
    int            lag = 4;
    logic [ND-1:0] tie_mask = '0;
    logic [ND-1:0] tie_val  = '0;

    int end_q[$];
    int start_q[$];
    int req1 = -1;
    int req2 = -1;

    int r_fall, r_rise, r_done, r_ndone, r_nfall, r_nrise, r_stray;
    logic r_busy0, r_block0, r_axi0, r_busy_d, r_block_d;
    logic [1:0] r_stat0, r_stat, r_stat_late;

    // One clock edge; afterwards update the domain feedback model.
    task automatic tick();
        @(posedge clk);
        #1;
        for (int i = LAG_MAX - 1; i > 0; i--) hist[i] = hist[i-1];
        hist[0] = axi_n;
        dom = ({ND{hist[lag-1]}} & ~tie_mask) | (tie_val & tie_mask);
    endtask

    function automatic bit in_q(input int q[$], input int v);
        foreach (q[i]) if (q[i] == v) return 1'b1;
        return 1'b0;
    endfunction

    task automatic drive(input logic s, input logic e, input int n);
        ts = s; te = e;
        repeat (n) tick();
        ts = 1'b0; te = 1'b0;
    endtask

    // Issue a request and record event offsets relative to the request edge.
    task automatic run_seq();
        int   off;
        logic pa;
        r_fall = -1; r_rise = -1; r_done = -1;
        r_ndone = 0; r_nfall = 0; r_nrise = 0; r_stray = 0;
        r_stat = 2'bxx; r_busy_d = 1'bx; r_block_d = 1'bx;
        ts = 1'b0; te = 1'b0;
        req = 1'b1;
        tick();
        req = 1'b0;
        r_busy0 = busy; r_block0 = block; r_stat0 = status; r_axi0 = axi_n;
        pa  = axi_n;
        off = 0;
        while (off < 12000) begin
            off++;
            te  = in_q(end_q, off);
            ts  = in_q(start_q, off);
            req = (off == req1) || (off == req2);
            tick();
            if (pa && !axi_n) begin r_nfall++; if (r_fall < 0) r_fall = off; end
            if (!pa && axi_n) begin r_nrise++; if (r_rise < 0) r_rise = off; end
            pa = axi_n;
            if (done === 1'b1) begin
                r_ndone++;
                if (r_done < 0) begin
                    r_done = off; r_stat = status; r_busy_d = busy; r_block_d = block;
                end
            end
            if (r_done >= 0 && off > r_done && busy !== 1'b0) r_stray++;
            if (r_done >= 0 && off >= r_done + 20) break;
        end
        ts = 1'b0; te = 1'b0; req = 1'b0;
        r_stat_late = status;
        end_q.delete(); start_q.delete(); req1 = -1; req2 = -1;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (3) tick();
        n_vec++; if (axi_n !== 1'b1) begin n_err++; $display("FAIL reset_axi got=%b exp=1", axi_n); end
        n_vec++; if (block !== 1'b0) begin n_err++; $display("FAIL reset_block got=%b exp=0", block); end
        n_vec++; if (busy !== 1'b0) begin n_err++; $display("FAIL reset_busy got=%b exp=0", busy); end
        n_vec++; if (done !== 1'b0) begin n_err++; $display("FAIL reset_done got=%b exp=0", done); end
        n_vec++; if (status !== 2'b00) begin n_err++; $display("FAIL reset_status got=%b exp=00", status); end
        rst = 1'b0;
        repeat (10) tick();
    endtask

    task automatic test_idle_request();
        lag = 4;
        run_seq();
        n_vec++; if (r_busy0 !== 1'b1 || r_block0 !== 1'b1) begin n_err++; $display("FAIL idle_busy_block got=%b%b exp=11", r_busy0, r_block0); end
        n_vec++; if (r_axi0 !== 1'b1) begin n_err++; $display("FAIL idle_axi_at_req got=%b exp=1", r_axi0); end
        n_vec++; if (r_fall !== 1) begin n_err++; $display("FAIL idle_fall got=%0d exp=1", r_fall); end
        n_vec++; if (r_rise - r_fall !== PULSE) begin n_err++; $display("FAIL idle_width got=%0d exp=%0d", r_rise - r_fall, PULSE); end
        n_vec++; if (r_done !== 1 + PULSE + lag + SYNC) begin n_err++; $display("FAIL idle_done got=%0d exp=%0d", r_done, 1 + PULSE + lag + SYNC); end
        n_vec++; if (r_ndone !== 1) begin n_err++; $display("FAIL idle_ndone got=%0d exp=1", r_ndone); end
        n_vec++; if (r_stat !== 2'b00) begin n_err++; $display("FAIL idle_status got=%b exp=00", r_stat); end
        n_vec++; if (r_busy_d !== 1'b0 || r_block_d !== 1'b0) begin n_err++; $display("FAIL idle_release got=%b%b exp=00", r_busy_d, r_block_d); end
        n_vec++; if (r_stray !== 0 || r_nfall !== 1) begin n_err++; $display("FAIL idle_quiet got=%0d/%0d exp=0/1", r_stray, r_nfall); end
    endtask

    task automatic test_drain();
        drive(1'b1, 1'b0, 3);
        end_q = '{10, 20, 30};
        run_seq();
        n_vec++; if (r_fall !== 31) begin n_err++; $display("FAIL drain_fall got=%0d exp=31", r_fall); end
        n_vec++; if (r_rise !== 31 + PULSE) begin n_err++; $display("FAIL drain_rise got=%0d exp=%0d", r_rise, 31 + PULSE); end
        n_vec++; if (r_stat !== 2'b00) begin n_err++; $display("FAIL drain_status got=%b exp=00", r_stat); end
    endtask

    task automatic test_drain_timeout();
        drive(1'b1, 1'b0, 1);
        start_q = '{5};      // counted even while blocked, discarded at reset entry
        run_seq();
        n_vec++; if (r_fall !== QTO) begin n_err++; $display("FAIL dto_fall got=%0d exp=%0d", r_fall, QTO); end
        n_vec++; if (r_stat !== 2'b01) begin n_err++; $display("FAIL dto_status got=%b exp=01", r_stat); end
        n_vec++; if (r_stat_late !== 2'b01) begin n_err++; $display("FAIL dto_status_held got=%b exp=01", r_stat_late); end
        n_vec++; if (r_done !== QTO + PULSE + lag + SYNC) begin n_err++; $display("FAIL dto_done got=%0d exp=%0d", r_done, QTO + PULSE + lag + SYNC); end
        run_seq();
        n_vec++; if (r_stat0 !== 2'b00) begin n_err++; $display("FAIL dto_status_clear got=%b exp=00", r_stat0); end
        n_vec++; if (r_fall !== 1) begin n_err++; $display("FAIL dto_count_zero got=%0d exp=1", r_fall); end
    endtask

    task automatic test_hs_timeout();
        tie_mask = 5'b00100; tie_val = 5'b00100;
        run_seq();
        n_vec++; if (r_rise - r_fall !== HTO) begin n_err++; $display("FAIL hs_in_width got=%0d exp=%0d", r_rise - r_fall, HTO); end
        n_vec++; if (r_stat !== 2'b10) begin n_err++; $display("FAIL hs_in_status got=%b exp=10", r_stat); end
        n_vec++; if (r_done !== 1 + HTO + lag + SYNC) begin n_err++; $display("FAIL hs_in_done got=%0d exp=%0d", r_done, 1 + HTO + lag + SYNC); end
        tie_val = 5'b00000;
        repeat (10) tick();
        run_seq();
        n_vec++; if (r_rise - r_fall !== PULSE) begin n_err++; $display("FAIL hs_out_width got=%0d exp=%0d", r_rise - r_fall, PULSE); end
        n_vec++; if (r_done - r_rise !== HTO) begin n_err++; $display("FAIL hs_out_wait got=%0d exp=%0d", r_done - r_rise, HTO); end
        n_vec++; if (r_stat !== 2'b10) begin n_err++; $display("FAIL hs_out_status got=%b exp=10", r_stat); end
        tie_mask = '0; tie_val = '0;
        repeat (10) tick();
    endtask

    task automatic test_counter_edges();
        drive(1'b1, 1'b1, 4);
        run_seq();
        n_vec++; if (r_fall !== 1) begin n_err++; $display("FAIL cnt_simul got=%0d exp=1", r_fall); end
        drive(1'b0, 1'b1, 3);
        drive(1'b1, 1'b0, 1);
        end_q = '{5};
        run_seq();
        n_vec++; if (r_fall !== 6) begin n_err++; $display("FAIL cnt_underflow got=%0d exp=6", r_fall); end
        drive(1'b1, 1'b0, 300);
        drive(1'b0, 1'b1, 254);
        end_q = '{10};
        run_seq();
        n_vec++; if (r_fall !== 11) begin n_err++; $display("FAIL cnt_saturate got=%0d exp=11", r_fall); end
        req1 = 5;                                  // lands in ASSERT
        req2 = 1 + PULSE + lag + SYNC + 1;         // lands in DONE
        run_seq();
        n_vec++; if (r_ndone !== 1) begin n_err++; $display("FAIL req_ignored_ndone got=%0d exp=1", r_ndone); end
        n_vec++; if (r_nfall !== 1 || r_stray !== 0) begin n_err++; $display("FAIL req_ignored_extra got=%0d/%0d exp=1/0", r_nfall, r_stray); end
        n_vec++; if (r_rise !== 1 + PULSE) begin n_err++; $display("FAIL req_ignored_rise got=%0d exp=%0d", r_rise, 1 + PULSE); end
    endtask

    task automatic test_mid_reset();
        req = 1'b1; tick(); req = 1'b0;
        repeat (8) tick();
        n_vec++; if (axi_n !== 1'b0) begin n_err++; $display("FAIL mid_pre_axi got=%b exp=0", axi_n); end
        rst = 1'b1; tick(); rst = 1'b0;
        n_vec++; if (axi_n !== 1'b1) begin n_err++; $display("FAIL mid_axi got=%b exp=1", axi_n); end
        n_vec++; if (busy !== 1'b0 || block !== 1'b0) begin n_err++; $display("FAIL mid_busy_block got=%b%b exp=00", busy, block); end
        n_vec++; if (status !== 2'b00 || done !== 1'b0) begin n_err++; $display("FAIL mid_status_done got=%b/%b exp=00/0", status, done); end
        repeat (30) tick();
        n_vec++; if (busy !== 1'b0 || axi_n !== 1'b1) begin n_err++; $display("FAIL mid_idle got=%b%b exp=01", busy, axi_n); end
        run_seq();
        n_vec++; if (r_fall !== 1 || r_rise !== 1 + PULSE) begin n_err++; $display("FAIL mid_fresh got=%0d/%0d exp=1/%0d", r_fall, r_rise, 1 + PULSE); end
        n_vec++; if (r_done !== 1 + PULSE + lag + SYNC || r_stat !== 2'b00) begin n_err++; $display("FAIL mid_fresh_done got=%0d/%b exp=%0d/00", r_done, r_stat, 1 + PULSE + lag + SYNC); end
    endtask

    task automatic test_random();
        for (int it = 0; it < 8; it++) begin
            int c, o, e_fall, e_rise, e_done;
            lag = $urandom_range(1, 20);
            c   = $urandom_range(0, 4);
            repeat (LAG_MAX) tick();
            if (c > 0) drive(1'b1, 1'b0, c);
            o = 0;
            for (int j = 0; j < c; j++) begin
                o += $urandom_range(1, 40);
                end_q.push_back(o);
            end
            e_fall = (c == 0) ? 1 : o + 1;
            e_rise = e_fall + ((PULSE > lag + SYNC) ? PULSE : lag + SYNC);
            e_done = e_rise + lag + SYNC;
            run_seq();
            n_vec++; if (r_fall !== e_fall) begin n_err++; $display("FAIL rnd%0d_fall got=%0d exp=%0d", it, r_fall, e_fall); end
            n_vec++; if (r_rise !== e_rise) begin n_err++; $display("FAIL rnd%0d_rise got=%0d exp=%0d", it, r_rise, e_rise); end
            n_vec++; if (r_done !== e_done) begin n_err++; $display("FAIL rnd%0d_done got=%0d exp=%0d", it, r_done, e_done); end
            n_vec++; if (r_stat !== 2'b00 || r_ndone !== 1) begin n_err++; $display("FAIL rnd%0d_status got=%b/%0d exp=00/1", it, r_stat, r_ndone); end
        end
        lag = 4;
        repeat (LAG_MAX) tick();
    endtask

    initial begin
        for (int i = 0; i < LAG_MAX; i++) hist[i] = 1'b1;
        rst = 1'b1; req = 1'b0; ts = 1'b0; te = 1'b0; dom = '1;
        test_reset();
        test_idle_request();
        test_drain();
        test_drain_timeout();
        test_hs_timeout();
        test_counter_edges();
        test_mid_reset();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
